model_lstm_gradient_applier: RTL and testbench
==============================================

Name: model_lstm_gradient_applier

Overview:
- Consumer end of the LSTM trainer's gradient output stream.
- Accepts weight-gradient elements dW[i][j] in row-major order and reads the current weight W[i][j] from external weight memory (1-cycle read latency).
- Computes W_new = W - eta*dW in signed fixed point with saturation, and emits W_new with its indices as a write stream back to weight memory.
- Sits between the LSTM trainer and the controller weight store.

Parameters:
- DATA_SIZE, 64, width of weights, gradients and learning rate (signed two's complement).
- CONTROL_SIZE, 64, width of size and index fields.
- FRAC_SIZE, 32, fractional bits of the fixed-point format (Q(DATA_SIZE-FRAC_SIZE).FRAC_SIZE).

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  one-cycle pulse: latch sizes and rate, begin a pass.
- READY  out  1  one-cycle pulse: pass complete.
- SIZE_I_IN  in  CONTROL_SIZE  row count.
- SIZE_J_IN  in  CONTROL_SIZE  column count.
- LEARNING_RATE_IN  in  DATA_SIZE  eta, fixed point.
- GRADIENT_IN  in  DATA_SIZE  dW element.
- GRADIENT_IN_ENABLE  in  1  gradient valid.
- GRADIENT_IN_READY  out  1  applier can accept a gradient.
- WEIGHT_READ_ENABLE  out  1  weight read strobe.
- WEIGHT_ADDR_I_OUT  out  CONTROL_SIZE  read row.
- WEIGHT_ADDR_J_OUT  out  CONTROL_SIZE  read column.
- WEIGHT_IN  in  DATA_SIZE  read data, valid the cycle after WEIGHT_READ_ENABLE.
- WEIGHT_OUT  out  DATA_SIZE  updated weight.
- WEIGHT_OUT_ENABLE  out  1  write strobe, one cycle per element.
- WEIGHT_OUT_I_OUT  out  CONTROL_SIZE  write row.
- WEIGHT_OUT_J_OUT  out  CONTROL_SIZE  write column.

Behaviour:
- Reset: every output is 0, FSM goes to IDLE, index counters i and j are 0, latched sizes and rate are 0. Reset takes priority over every other input in any state and abandons a pass in progress; no READY is issued for it.
- FSM states: IDLE, INPUT, READ, CALC, OUTPUT.
- IDLE:
  - START=1 latches SIZE_I_IN, SIZE_J_IN and LEARNING_RATE_IN, and clears i and j.
  - If either size is 0, READY pulses the next cycle and the FSM stays in IDLE.
  - Otherwise the FSM moves to INPUT.
- INPUT:
  - GRADIENT_IN_READY=1.
  - A handshake occurs on a cycle with GRADIENT_IN_ENABLE=1; GRADIENT_IN is registered and the FSM moves to READ.
  - Without a handshake the FSM stays in INPUT indefinitely.
- READ: WEIGHT_READ_ENABLE=1 for exactly one cycle with ADDR_I=i and ADDR_J=j, then CALC.
- CALC:
  - Sample WEIGHT_IN.
  - Compute the product p = eta*dW at full 2*DATA_SIZE signed width, then shift it arithmetically right by FRAC_SIZE, truncating toward minus infinity.
  - Compute W - p with one guard bit.
  - Saturate the result to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1] and register it.
  - Next state is OUTPUT.
- OUTPUT: WEIGHT_OUT_ENABLE=1 for one cycle, with WEIGHT_OUT and OUT_I/OUT_J = i, j. Then:
  - If j < SIZE_J-1: j++ and go to INPUT.
  - Else if i < SIZE_I-1: j=0, i++ and go to INPUT.
  - Else go to IDLE, with READY=1 on the first IDLE cycle.
- Strobe timing: GRADIENT_IN_READY, WEIGHT_READ_ENABLE, WEIGHT_OUT_ENABLE and READY are registered, one-cycle strobes, and are never asserted together.
- Throughput: 4 cycles per element minimum. Handshake to WEIGHT_OUT_ENABLE latency is 3 cycles.
- START outside IDLE is ignored; latched sizes and rate stay stable for the whole pass.
- WEIGHT_OUT, OUT_I and OUT_J hold their last value between strobes.
- Back-to-back passes: START is accepted on the READY cycle, since the FSM is in IDLE.
- GRADIENT_IN_ENABLE asserted outside INPUT is not consumed.

Test Plan:
- Defaults, sizes 1x1, eta=0x0000_0000_8000_0000 (0.5), dW=0x0000_0001_0000_0000 (1.0), WEIGHT_IN=0x0000_0001_0000_0000 -> one read at (0,0); WEIGHT_OUT=0x0000_0000_8000_0000 at (0,0) 3 cycles after the handshake; READY one cycle later.
- Sizes 2x3, constant dW, with GRADIENT_IN_ENABLE held high -> write indices (0,0),(0,1),(0,2),(1,0),(1,1),(1,2) in order, 4 cycles apart; exactly 6 reads and 6 writes; a single READY.
- Saturation: W=0x7FFF_FFFF_FFFF_FFFF, eta=1.0, dW=-1.0 -> WEIGHT_OUT=0x7FFF_FFFF_FFFF_FFFF; the mirrored case with W=0x8000_0000_0000_0000, eta=1.0, dW=1.0 -> WEIGHT_OUT=0x8000_0000_0000_0000.
- SIZE_I_IN=0 with START -> READY the next cycle; no READ or WRITE strobes; GRADIENT_IN_READY stays 0.
- Gradient stalls of random length, plus START pulses mid-pass -> results identical to the no-stall run; the extra STARTs are ignored.
- RST asserted during CALC of element (1,1) in a 2x2 pass -> all outputs 0 the next cycle and no READY; a new 1x1 pass then completes correctly.

Source files
------------

// File: rtl/model_lstm_gradient_applier_if.sv
// Gradient-in / weight-read / weight-write bundle between the LSTM trainer, the
// weight store and the gradient applier.
interface model_lstm_gradient_applier_if #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
);
  logic                    start;
  logic                    ready;
  logic [CONTROL_SIZE-1:0] size_i_in;
  logic [CONTROL_SIZE-1:0] size_j_in;
  logic [DATA_SIZE-1:0]    learning_rate_in;
  logic [DATA_SIZE-1:0]    gradient_in;
  logic                    gradient_in_enable;
  logic                    gradient_in_ready;
  logic                    weight_read_enable;
  logic [CONTROL_SIZE-1:0] weight_addr_i_out;
  logic [CONTROL_SIZE-1:0] weight_addr_j_out;
  logic [DATA_SIZE-1:0]    weight_in;
  logic [DATA_SIZE-1:0]    weight_out;
  logic                    weight_out_enable;
  logic [CONTROL_SIZE-1:0] weight_out_i_out;
  logic [CONTROL_SIZE-1:0] weight_out_j_out;

  modport master (
    output start, size_i_in, size_j_in, learning_rate_in, gradient_in,
           gradient_in_enable, weight_in,
    input  ready, gradient_in_ready, weight_read_enable, weight_addr_i_out,
           weight_addr_j_out, weight_out, weight_out_enable,
           weight_out_i_out, weight_out_j_out
  );

  modport slave (
    input  start, size_i_in, size_j_in, learning_rate_in, gradient_in,
           gradient_in_enable, weight_in,
    output ready, gradient_in_ready, weight_read_enable, weight_addr_i_out,
           weight_addr_j_out, weight_out, weight_out_enable,
           weight_out_i_out, weight_out_j_out
  );
endinterface

// File: rtl/model_lstm_gradient_applier.sv
// Applies W -= eta*dW (saturating fixed point) element by element; handshake to write strobe is
// 3 cycles, 4 cycles per element; gradients are only accepted while gradient_in_ready is high.
module model_lstm_gradient_applier #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int FRAC_SIZE    = 32
) (
  input logic clk,
  input logic rst,
  model_lstm_gradient_applier_if.slave bus
);
  localparam int W = DATA_SIZE;
  localparam logic [CONTROL_SIZE-1:0] ONE_C = 1;

  typedef enum logic [2:0] {IDLE, INPUT, READ, CALC, OUTPUT} state_t;

  state_t                  state;
  logic [CONTROL_SIZE-1:0] size_i;
  logic [CONTROL_SIZE-1:0] size_j;
  logic [CONTROL_SIZE-1:0] i_cnt;
  logic [CONTROL_SIZE-1:0] j_cnt;
  logic [W-1:0]            rate;
  logic [W-1:0]            grad;

  logic [2*W-1:0] prod;
  logic [W-1:0]   p_trunc;
  logic [W:0]     diff;
  logic [W-1:0]   w_sat;
  logic           prod_unused;
  logic           last_i;
  logic           last_j;

  // Low W bits of (prod >>> FRAC_SIZE) are exactly this slice; sign fill never reaches them.
  always_comb begin
    prod    = {{W{rate[W-1]}}, rate} * {{W{grad[W-1]}}, grad};
    p_trunc = prod[FRAC_SIZE +: W];
    diff    = {bus.weight_in[W-1], bus.weight_in} - {p_trunc[W-1], p_trunc};
    w_sat   = diff[W-1:0];
    if (diff[W] != diff[W-1]) begin
      w_sat = diff[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

  assign prod_unused = ^{prod[2*W-1:FRAC_SIZE+W], prod[FRAC_SIZE-1:0]};
  assign last_i      = (i_cnt == size_i - ONE_C);
  assign last_j      = (j_cnt == size_j - ONE_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      state                  <= IDLE;
      size_i                 <= '0;
      size_j                 <= '0;
      rate                   <= '0;
      grad                   <= '0;
      i_cnt                  <= '0;
      j_cnt                  <= '0;
      bus.ready              <= 1'b0;
      bus.gradient_in_ready  <= 1'b0;
      bus.weight_read_enable <= 1'b0;
      bus.weight_addr_i_out  <= '0;
      bus.weight_addr_j_out  <= '0;
      bus.weight_out         <= '0;
      bus.weight_out_enable  <= 1'b0;
      bus.weight_out_i_out   <= '0;
      bus.weight_out_j_out   <= '0;
    end else begin
      bus.ready              <= 1'b0;
      bus.gradient_in_ready  <= 1'b0;
      bus.weight_read_enable <= 1'b0;
      bus.weight_out_enable  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            size_i <= bus.size_i_in;
            size_j <= bus.size_j_in;
            rate   <= bus.learning_rate_in;
            i_cnt  <= '0;
            j_cnt  <= '0;
            if (bus.size_i_in == '0 || bus.size_j_in == '0) begin
              bus.ready <= 1'b1;
            end else begin
              state                 <= INPUT;
              bus.gradient_in_ready <= 1'b1;
            end
          end
        end
        INPUT: begin
          if (bus.gradient_in_enable) begin
            grad                   <= bus.gradient_in;
            state                  <= READ;
            bus.weight_read_enable <= 1'b1;
            bus.weight_addr_i_out  <= i_cnt;
            bus.weight_addr_j_out  <= j_cnt;
          end else begin
            bus.gradient_in_ready <= 1'b1;
          end
        end
        READ: state <= CALC;
        CALC: begin
          bus.weight_out        <= w_sat;
          bus.weight_out_enable <= 1'b1;
          bus.weight_out_i_out  <= i_cnt;
          bus.weight_out_j_out  <= j_cnt;
          state                 <= OUTPUT;
        end
        OUTPUT: begin
          if (!last_j) begin
            j_cnt                 <= j_cnt + ONE_C;
            state                 <= INPUT;
            bus.gradient_in_ready <= 1'b1;
          end else if (!last_i) begin
            j_cnt                 <= '0;
            i_cnt                 <= i_cnt + ONE_C;
            state                 <= INPUT;
            bus.gradient_in_ready <= 1'b1;
          end else begin
            state     <= IDLE;
            bus.ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_model_lstm_gradient_applier.sv
// Bench for model_lstm_gradient_applier: directed vector table, held-enable and zero-size cases,
// random passes with stalls and stray STARTs, back-to-back passes and a mid-pass reset.
module tb_model_lstm_gradient_applier;
  localparam int DW = 64;
  localparam int CW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  model_lstm_gradient_applier_if #(.DATA_SIZE(DW), .CONTROL_SIZE(CW)) bus ();
  model_lstm_gradient_applier #(.DATA_SIZE(DW), .CONTROL_SIZE(CW), .FRAC_SIZE(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {logic [63:0] i; logic [63:0] j; logic [63:0] d; int c;} wr_t;
  typedef struct {logic [63:0] i; logic [63:0] j;} rd_t;
  typedef struct {logic [63:0] eta; logic [63:0] dw; logic [63:0] w; logic [63:0] exp;} vec_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rdy_cnt = 0;
  int ovl = 0;
  int rdy_seen_cyc = 0;
  wr_t wr_q[$];
  rd_t rd_q[$];
  logic [63:0] wmem [4][4];
  logic [63:0] grads [4][4];
  int hs_cyc [16];

  always @(posedge clk) cyc <= cyc + 1;

  // Weight store: 1-cycle read latency
  always @(posedge clk)
    if (bus.weight_read_enable)
      bus.weight_in <= wmem[bus.weight_addr_i_out[1:0]][bus.weight_addr_j_out[1:0]];

  always @(negedge clk) begin
    if (bus.weight_read_enable) rd_q.push_back('{bus.weight_addr_i_out, bus.weight_addr_j_out});
    if (bus.weight_out_enable)
      wr_q.push_back('{bus.weight_out_i_out, bus.weight_out_j_out, bus.weight_out, cyc});
    if (bus.ready) rdy_cnt++;
    if (int'(bus.ready) + int'(bus.gradient_in_ready) + int'(bus.weight_read_enable)
        + int'(bus.weight_out_enable) > 1) ovl++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  // W - floor(eta*dW / 2^32), clamped to the signed 64-bit range
  function automatic logic [63:0] model(input logic [63:0] w, input logic [63:0] eta,
                                        input logic [63:0] dw);
    logic signed [127:0] sw, se, sd, p, d, hi, lo;
    sw = {{64{w[63]}}, w};
    se = {{64{eta[63]}}, eta};
    sd = {{64{dw[63]}}, dw};
    p  = (se * sd) >>> 32;
    d  = sw - p;
    hi = 128'sh7FFF_FFFF_FFFF_FFFF;
    lo = -hi - 128'sd1;
    if (d > hi) return hi[63:0];
    if (d < lo) return lo[63:0];
    return d[63:0];
  endfunction

  function automatic logic [63:0] rnd_small(input int bits);
    logic [63:0] t;
    t = {$urandom, $urandom};
    t = t << (64 - bits);
    return $signed(t) >>> (64 - bits);
  endfunction

  function automatic logic [63:0] rnd_weight();
    case ($urandom_range(2, 0))
      0:       return {$urandom, $urandom};
      1:       return 64'h7FFF_FFFF_FFFF_FFFF - {32'd0, $urandom};
      default: return 64'h8000_0000_0000_0000 + {32'd0, $urandom};
    endcase
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, " ready"}, 64'(bus.ready), 0);
    chk({tag, " gin_rdy"}, 64'(bus.gradient_in_ready), 0);
    chk({tag, " rd_en"}, 64'(bus.weight_read_enable), 0);
    chk({tag, " addr_i"}, bus.weight_addr_i_out, 0);
    chk({tag, " addr_j"}, bus.weight_addr_j_out, 0);
    chk({tag, " wout"}, bus.weight_out, 0);
    chk({tag, " wout_en"}, 64'(bus.weight_out_enable), 0);
    chk({tag, " out_i"}, bus.weight_out_i_out, 0);
    chk({tag, " out_j"}, bus.weight_out_j_out, 0);
  endtask

  // Present g and wait (bounded) for the cycle in which it is accepted.
  task automatic feed(input logic [63:0] g, input int k, output bit ok);
    bus.gradient_in        = g;
    bus.gradient_in_enable = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      if (bus.gradient_in_ready) begin
        ok = 1'b1;
        hs_cyc[k] = cyc;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) chk($sformatf("handshake timeout k=%0d", k), 0, 1);
  endtask

  task automatic run_pass(input int si, input int sj, input logic [63:0] eta, input int stall_max,
                          input bit hold_en, input bit noise, input bit chain, input string tag);
    int n, st, rdy0, ii, jj;
    bit ok;
    n = si * sj;
    wr_q.delete();
    rd_q.delete();
    bus.size_i_in        = 64'(si);
    bus.size_j_in        = 64'(sj);
    bus.learning_rate_in = eta;
    bus.start            = 1'b1;
    @(posedge clk);
    #1;
    bus.start            = 1'b0;
    rdy0                 = rdy_cnt;
    bus.size_i_in        = '0;
    bus.size_j_in        = 64'd5;
    bus.learning_rate_in = ~eta;
    ok = 1'b1;
    for (int k = 0; k < n && ok; k++) begin
      st = (stall_max > 0) ? int'($urandom_range(stall_max, 0)) : 0;
      if (!hold_en) bus.gradient_in_enable = 1'b0;
      repeat (st) begin
        bus.start = noise && ($urandom_range(2, 0) == 0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
      end
      feed(grads[k / sj][k % sj], k, ok);
      if (!hold_en) bus.gradient_in_enable = 1'b0;
    end
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (bus.ready) begin
        ok = 1'b1;
        rdy_seen_cyc = cyc;
      end
    end
    bus.gradient_in_enable = 1'b0;
    chk({tag, " ready seen"}, 64'(ok), 1);
    chk({tag, " reads"}, 64'(rd_q.size()), 64'(n));
    chk({tag, " writes"}, 64'(wr_q.size()), 64'(n));
    for (int k = 0; k < n && k < wr_q.size() && k < rd_q.size(); k++) begin
      ii = k / sj;
      jj = k % sj;
      chk($sformatf("%s rd%0d i", tag, k), rd_q[k].i, 64'(ii));
      chk($sformatf("%s rd%0d j", tag, k), rd_q[k].j, 64'(jj));
      chk($sformatf("%s wr%0d i", tag, k), wr_q[k].i, 64'(ii));
      chk($sformatf("%s wr%0d j", tag, k), wr_q[k].j, 64'(jj));
      chk($sformatf("%s wr%0d data", tag, k), wr_q[k].d, model(wmem[ii][jj], eta, grads[ii][jj]));
      chk($sformatf("%s wr%0d latency", tag, k), 64'(wr_q[k].c - hs_cyc[k]), 3);
    end
    if (n > 0 && wr_q.size() == n)
      chk({tag, " ready after last write"}, 64'(rdy_seen_cyc - wr_q[n-1].c), 1);
    if (!chain) begin
      repeat (3) begin
        @(posedge clk);
        #1;
      end
      chk({tag, " ready count"}, 64'(rdy_cnt - rdy0), 1);
    end
  endtask

  task automatic zero_case(input int si, input int sj, input string tag);
    int seen;
    bus.size_i_in          = 64'(si);
    bus.size_j_in          = 64'(sj);
    bus.gradient_in_enable = 1'b1;
    bus.start              = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk({tag, " ready"}, 64'(bus.ready), 1);
    chk({tag, " gin_rdy"}, 64'(bus.gradient_in_ready), 0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen += int'(bus.ready) + int'(bus.gradient_in_ready) + int'(bus.weight_read_enable)
              + int'(bus.weight_out_enable);
    end
    chk({tag, " quiet after"}, 64'(seen), 0);
    bus.gradient_in_enable = 1'b0;
    @(posedge clk);
    #1;
  endtask

  vec_t vt [8];

  initial begin
    int si, sj, rdy0;
    logic [63:0] eta;
    bit ok;

    vt[0] = '{64'h0000_0000_8000_0000, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 64'h0000_0000_8000_0000};
    vt[1] = '{64'h0000_0001_0000_0000, 64'hFFFF_FFFF_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF};
    vt[2] = '{64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
    vt[3] = '{64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h1};
    vt[4] = '{64'h1, 64'h1, 64'h5, 64'h5};
    vt[5] = '{64'h0000_0002_0000_0000, 64'h0000_0000_4000_0000, 64'h0, 64'hFFFF_FFFF_8000_0000};
    vt[6] = '{64'hFFFF_FFFF_0000_0000, 64'h0000_0003_0000_0000, 64'h0000_0001_0000_0000, 64'h0000_0004_0000_0000};
    vt[7] = '{64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFE, 64'h7FFF_FFFF_FFFF_FFFF};

    bus.start = 1'b0;
    bus.size_i_in = '0;
    bus.size_j_in = '0;
    bus.learning_rate_in = '0;
    bus.gradient_in = '0;
    bus.gradient_in_enable = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      wmem[0][0]  = vt[v].w;
      grads[0][0] = vt[v].dw;
      run_pass(1, 1, vt[v].eta, 0, 1'b0, 1'b0, 1'b0, $sformatf("vec%0d", v));
      if (wr_q.size() > 0) chk($sformatf("vec%0d table", v), wr_q[0].d, vt[v].exp);
    end

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        wmem[i][j]  = rnd_weight();
        grads[i][j] = 64'h0000_0000_4000_0000;
      end
    run_pass(2, 3, 64'h0000_0000_8000_0000, 0, 1'b1, 1'b0, 1'b0, "held");
    for (int k = 1; k < wr_q.size(); k++)
      chk($sformatf("held spacing %0d", k), 64'(wr_q[k].c - wr_q[k-1].c), 4);

    zero_case(0, 3, "zero_i");
    zero_case(2, 0, "zero_j");

    for (int r = 0; r < 6; r++) begin
      si  = int'($urandom_range(4, 1));
      sj  = int'($urandom_range(4, 1));
      eta = rnd_small(35);
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          wmem[i][j]  = rnd_weight();
          grads[i][j] = rnd_small(41);
        end
      run_pass(si, sj, eta, 0, 1'b0, 1'b0, 1'b0, $sformatf("rnd%0d", r));
      run_pass(si, sj, eta, 5, 1'b0, 1'b1, 1'b0, $sformatf("stall%0d", r));
    end

    wmem[0][0]  = 64'h0000_0003_0000_0000;
    grads[0][0] = 64'h0000_0001_0000_0000;
    run_pass(1, 1, 64'h0000_0000_8000_0000, 0, 1'b0, 1'b0, 1'b1, "b2b_a");
    run_pass(1, 1, 64'h0000_0001_0000_0000, 0, 1'b0, 1'b0, 1'b0, "b2b_b");

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        wmem[i][j]  = rnd_weight();
        grads[i][j] = rnd_small(41);
      end
    wr_q.delete();
    bus.size_i_in = 64'd2;
    bus.size_j_in = 64'd2;
    bus.learning_rate_in = 64'h0000_0001_0000_0000;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    rdy0 = rdy_cnt;
    ok = 1'b1;
    for (int k = 0; k < 4 && ok; k++) begin
      feed(grads[k / 2][k % 2], k, ok);
      bus.gradient_in_enable = 1'b0;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_zero("mid reset");
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    chk("mid reset ready count", 64'(rdy_cnt - rdy0), 0);
    chk("mid reset writes", 64'(wr_q.size()), 3);
    wmem[0][0]  = 64'h0000_0001_0000_0000;
    grads[0][0] = 64'h0000_0001_0000_0000;
    run_pass(1, 1, 64'h0000_0000_8000_0000, 0, 1'b0, 1'b0, 1'b0, "after reset");
    if (wr_q.size() > 0) chk("after reset value", wr_q[0].d, 64'h0000_0000_8000_0000);

    chk("strobe overlap", 64'(ovl), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
